counter_display_driver: RTL and testbench
=========================================

Name: counter_display_driver

Overview:
- Downstream consumer of the 10-bit event counter on the Elbert V2 board. Takes the counter's binary value, converts it to BCD with a sequential double-dabble engine, and drives the board's 3-digit multiplexed common-anode 7-segment display.
- The counter output changes on its own increment strobe, not on clk, so the input is filtered for stability before any conversion.

Parameters:
- REFRESH_DIV, 12000, clk cycles per digit slot; 12000 gives 1 kHz per digit at 12 MHz.
- BLANK_LZ, 1, 1 = blank leading zeros in hundreds/tens; the units digit always shows.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- value  input  10  binary count from the upstream counter, asynchronous to clk
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}
- digit_en  output  3  active-low digit enables; bit0 = units (rightmost), bit2 = hundreds
- busy  output  1  high while a conversion is in progress
- ovf  output  1  high while the displayed value is >999

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - seg=8'hFF, digit_en=3'b111, busy=0, ovf=0.
  - Sample regs s1/s2=0, cur=0, BCD display regs=0.
  - FSM goes to IDLE, digit index=0, refresh counter=0.
  - Reset mid-conversion aborts the conversion with no display update.
- Input filter:
  - Every edge: s1<=value, s2<=s1.
  - Value is "stable" when s1==s2.
  - Only a stable s2 is ever converted, so a value changing every cycle is never accepted.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when stable and s2!=cur. On this transition: capture s2 into cap, load shift reg {16'b0, s2}, iter=0.
  - SHIFT: each cycle, add 3 to every 4-bit BCD nibble (thousands, hundreds, tens, units) whose value is >=5, then shift the whole register left by 1. iter increments; after 10 shifts -> DONE.
  - DONE, one cycle:
    - Latch hundreds/tens/units into the display regs.
    - ovf<=(thousands!=0); cur<=cap.
    - -> IDLE.
  - busy = (state!=IDLE).
- Latency: value stable from edge N -> s2 valid at N+2 -> SHIFT entered at N+3 -> DONE at N+13 -> display regs and ovf updated at edge N+14.
- Input changes while busy are ignored. IDLE re-evaluates them after DONE, so the final stable value is always displayed.
- Display update is atomic: all digits and ovf change on the same edge.
- Multiplexing:
  - Refresh counter runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit index advances 0->1->2->0.
  - digit_en and seg are registered from the index and display regs. Both change on the same edge, so there is no ghosting.
  - From reset release: index 0 is driven on the first edge with rst_n=1.
  - Enable sequence: 3'b110 (units), 3'b101 (tens), 3'b011 (hundreds).
- Segment encoding, active-low, dp always off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF, dash=BF.
- Leading-zero blanking (BLANK_LZ=1):
  - Hundreds blank if 0.
  - Tens blank if hundreds==0 and tens==0.
  - Units never blank.
- Overflow: ovf=1 (cur 1000..1023) -> all three digits show dash; the blanking rules do not apply.
- Upstream counter wrap (1023->0): handled as an ordinary value change.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with value=10'd500 -> seg=8'hFF, digit_en=3'b111, busy=0, ovf=0. After release, units slot shows C0 and the other slots show FF until the 500 conversion completes.
- Basic conversion, REFRESH_DIV=4: value=937 stable from edge N -> busy rises at N+3 and falls at N+14. Display cycles 110/F8, 101/B0, 011/90, each slot held 4 cycles.
- Blanking: value=7 -> units F8, tens FF, hundreds FF. value=40 -> units C0, tens 99, hundreds FF.
- Overflow: value=1000, then 1023 -> ovf=1 and all slots BF. Then value=0 -> ovf=0 and units C0 at N+14.
- Glitch and busy: value toggles 5/6 every cycle for 20 cycles -> no conversion starts (busy stays 0). Then value=512 held -> displays 5,1,2. value=3 applied during busy -> 512 displayed first, then 3 with no extra stall.
- Reset mid-conversion: assert rst_n=0 at SHIFT iter 5 -> next edge busy=0, display regs 0. After release the stable value is reconverted in full.

Source files
------------

// File: rtl/counter_display_driver.sv
// Purpose: filter an asynchronous 10-bit count, convert it to BCD (double dabble), drive a 3-digit mux 7-seg.
// Latency: display/ovf update 14 edges after the input value settles (2 sync + 1 start + 10 shifts + 1 latch).
// Backpressure: none; input changes during a conversion are held off and re-evaluated once it completes.
module counter_display_driver #(
    parameter int REFRESH_DIV = 12000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] value,
    output logic [7:0] seg,
    output logic [2:0] digit_en,
    output logic       busy,
    output logic       ovf
);
    localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    s1_q, s2_q;
    logic [9:0]    cur_q, cur_d;
    logic [9:0]    cap_q, cap_d;
    // {thousands, hundreds, tens, units, binary}
    logic [25:0]   sh_q, sh_d, sh_adj;
    logic [3:0]    iter_q, iter_d;
    logic [3:0]    hund_q, hund_d, tens_q, tens_d, units_q, units_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] rcnt_q;
    logic [1:0]    idx_q;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    en_q, en_d;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'hC0;
            4'd1:    enc = 8'hF9;
            4'd2:    enc = 8'hA4;
            4'd3:    enc = 8'hB0;
            4'd4:    enc = 8'h99;
            4'd5:    enc = 8'h92;
            4'd6:    enc = 8'h82;
            4'd7:    enc = 8'hF8;
            4'd8:    enc = 8'h80;
            4'd9:    enc = 8'h90;
            default: enc = 8'hFF;
        endcase
    endfunction

    // Two-stage sampler; a value is only trusted once both stages agree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= value;
            s2_q <= s1_q;
        end
    end

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        sh_adj = sh_q;
        for (int n = 0; n < 4; n++) begin
            if (sh_q[10+4*n +: 4] >= 4'd5) begin
                sh_adj[10+4*n +: 4] = sh_q[10+4*n +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM next-state: start on a new stable value, shift 10 times, then latch atomically.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        iter_d  = iter_q;
        cap_d   = cap_q;
        cur_d   = cur_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if ((s1_q == s2_q) && (s2_q != cur_q)) begin
                    state_d = SHIFT;
                    cap_d   = s2_q;
                    sh_d    = {16'b0, s2_q};
                    iter_d  = 4'd0;
                end
            end
            SHIFT: begin
                sh_d   = {sh_adj[24:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd9) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hund_d  = sh_q[21:18];
                tens_d  = sh_q[17:14];
                units_d = sh_q[13:10];
                ovf_d   = (sh_q[25:22] != 4'd0);
                cur_d   = cap_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion FSM and display registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            iter_q  <= '0;
            cap_q   <= '0;
            cur_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            iter_q  <= iter_d;
            cap_q   <= cap_d;
            cur_q   <= cur_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            ovf_q   <= ovf_d;
        end
    end

    // Segment pattern for the current slot, with leading-zero blanking and overflow dashes.
    always_comb begin
        seg_d = 8'hFF;
        en_d  = 3'b111;
        case (idx_q)
            2'd0: begin
                en_d  = 3'b110;
                seg_d = enc(units_q);
            end
            2'd1: begin
                en_d  = 3'b101;
                seg_d = (BLANK_LZ && (hund_q == 4'd0) && (tens_q == 4'd0)) ? 8'hFF : enc(tens_q);
            end
            2'd2: begin
                en_d  = 3'b011;
                seg_d = (BLANK_LZ && (hund_q == 4'd0)) ? 8'hFF : enc(hund_q);
            end
            default: ;
        endcase
        if (ovf_q && (idx_q != 2'd3)) begin
            seg_d = 8'hBF;
        end
    end

    // Refresh timer and digit scan; seg and enables register together so no ghosting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            idx_q  <= 2'd0;
            seg_q  <= 8'hFF;
            en_q   <= 3'b111;
        end else begin
            seg_q <= seg_d;
            en_q  <= en_d;
            if (rcnt_q == CNT_MAX) begin
                rcnt_q <= '0;
                idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end

    assign seg      = seg_q;
    assign digit_en = en_q;
    assign busy     = (state_q != IDLE);
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_counter_display_driver.sv
// Purpose: randomized + directed check of counter_display_driver against a cycle-level arithmetic model.
// Latency: model predicts a display update 11 edges after a conversion starts.
// Backpressure: n/a (bench drives inputs freely).
module tb_counter_display_driver;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] value;
    logic [7:0] seg;
    logic [2:0] digit_en;
    logic       busy;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_s1, m_s2, m_cur, m_cap, m_cnt, m_k;
    int         m_h, m_t, m_u;
    bit         m_ovf;
    logic [7:0] e_seg;
    logic [2:0] e_en;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    counter_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .seg      (seg),
        .digit_en (digit_en),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] slot_seg(input int slot);
        if (m_ovf) return 8'hBF;
        case (slot)
            0:       return seg_tab[m_u];
            1:       return (m_h == 0 && m_t == 0) ? 8'hFF : seg_tab[m_t];
            default: return (m_h == 0) ? 8'hFF : seg_tab[m_h];
        endcase
    endfunction

    // One clock: advance the model with the inputs the DUT sampled, then compare all outputs.
    task automatic tick();
        int slot;
        @(posedge clk);
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_cur = 0; m_cap = 0; m_cnt = 0; m_k = 0;
            m_h = 0; m_t = 0; m_u = 0; m_ovf = 1'b0;
            e_seg = 8'hFF;
            e_en  = 3'b111;
        end else begin
            slot  = (m_k / DIV) % 3;
            e_en  = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
            e_seg = slot_seg(slot);
            m_k++;
            if (m_cnt == 0) begin
                if (m_s1 == m_s2 && m_s2 != m_cur) begin
                    m_cap = m_s2;
                    m_cnt = 11;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_cur = m_cap;
                    m_ovf = (m_cap > 999);
                    m_h   = (m_cap / 100) % 10;
                    m_t   = (m_cap / 10) % 10;
                    m_u   = m_cap % 10;
                end
            end
            m_s2 = m_s1;
            m_s1 = int'(value);
        end
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("digit_en", 32'(digit_en), 32'(e_en));
        check("busy", 32'(busy), 32'(m_cnt > 0));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic hold(input int v, input int n);
        value = 10'(v);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        value = 10'd500;
        repeat (3) tick();
        rst_n = 1'b1;
        hold(500, 40);

        // Directed patterns: three-digit, blanking, overflow, wrap back to zero
        hold(937, 40);
        hold(7, 30);
        hold(40, 30);
        hold(1000, 30);
        hold(1023, 30);
        hold(0, 30);

        // Glitching input must never start a conversion
        for (int i = 0; i < 20; i++) begin
            value = (i % 2 == 0) ? 10'd5 : 10'd6;
            tick();
        end

        // New value arriving mid-conversion is picked up right after
        hold(512, 6);
        hold(3, 40);

        // Reset at shift iteration 5, then full reconversion
        value = 10'd321;
        for (int i = 0; i < 30 && m_cnt != 6; i++) tick();
        check("busy_mid", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        hold(321, 40);

        // Random holds, with occasional glitch bursts and 1023->0 wraps
        for (int r = 0; r < 150; r++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                hold(1023, int'($urandom_range(5, 25)));
                hold(0, int'($urandom_range(5, 25)));
            end else if (sel == 1) begin
                repeat (int'($urandom_range(2, 12))) begin
                    value = 10'($urandom_range(0, 1023));
                    tick();
                end
            end else begin
                hold(int'($urandom_range(0, 1023)), int'($urandom_range(1, 30)));
            end
        end
        hold(int'(value), 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
